// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave port between the inst-fetch and data masters. One
// transaction at a time; data first, with a starvation guard for inst fetch.

module sram_like_arbiter_checker (
  input logic clk,
  input logic resetn,
  input logic in_addr,
  input logic grant_inst,
  input logic inst_req,
  input logic data_req,
  input logic s_data_ok
);
  // a granted master must keep requesting until its address is accepted
  req_held: assert property (@(posedge clk) disable iff (!resetn)
    in_addr |-> (grant_inst ? inst_req : data_req));
  // slave may not finish the data phase in the address-accept cycle
  no_early_data: assert property (@(posedge clk) disable iff (!resetn)
    in_addr |-> !s_data_ok);
endmodule

module sram_like_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              mem_stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_r, state_s;
  logic       grant_inst_r, grant_inst_s;
  logic [3:0] starve_cnt_r, starve_cnt_s;
  logic       pick_inst_s;
  logic       inst_busy_s, data_busy_s;

  // state, grant and starvation counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      grant_inst_r <= 1'b0;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_s;
      grant_inst_r <= grant_inst_s;
      starve_cnt_r <= starve_cnt_s;
    end
  end

  // grant decision in IDLE, phase sequencing in ADDR/DATA
  always_comb begin
    state_s      = state_r;
    grant_inst_s = grant_inst_r;
    starve_cnt_s = starve_cnt_r;
    pick_inst_s  = inst_req & (~data_req | (starve_cnt_r == LIMIT));
    case (state_r)
      IDLE: begin
        if (pick_inst_s) begin
          grant_inst_s = 1'b1;
          starve_cnt_s = 4'd0;
          state_s      = ADDR;
        end else if (data_req) begin
          grant_inst_s = 1'b0;
          state_s      = ADDR;
          // data wins over a waiting inst: count towards forcing inst first
          if (inst_req && (starve_cnt_r != LIMIT)) begin
            starve_cnt_s = starve_cnt_r + 4'd1;
          end else begin
            starve_cnt_s = starve_cnt_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (s_addr_ok) begin
          state_s = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (s_data_ok) begin
          state_s = IDLE;
        end else begin
          state_s = DATA;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // slave command mux and per-master handshake routing
  always_comb begin
    s_req        = 1'b0;
    s_wr         = 1'b0;
    s_size       = 2'd0;
    s_addr       = {ADDR_W{1'b0}};
    s_wdata      = {DATA_W{1'b0}};
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_r)
      ADDR: begin
        s_req = 1'b1;
        if (grant_inst_r) begin
          s_wr         = inst_wr;
          s_size       = inst_size;
          s_addr       = inst_addr;
          s_wdata      = inst_wdata;
          inst_addr_ok = s_addr_ok;
        end else begin
          s_wr         = data_wr;
          s_size       = data_size;
          s_addr       = data_addr;
          s_wdata      = data_wdata;
          data_addr_ok = s_addr_ok;
        end
      end
      DATA: begin
        if (grant_inst_r) begin
          inst_data_ok = s_data_ok;
        end else begin
          data_data_ok = s_data_ok;
        end
      end
      default: s_req = 1'b0;
    endcase
  end

  assign inst_busy_s = grant_inst_r & (state_r != IDLE);
  assign data_busy_s = ~grant_inst_r & (state_r != IDLE);

  // stall drops in the data_ok cycle so the pipeline advances on that edge
  assign mem_stall = ((inst_req | inst_busy_s) & ~inst_data_ok) |
                     ((data_req | data_busy_s) & ~data_data_ok);

  assign inst_rdata = s_rdata;
  assign data_rdata = s_rdata;

  sram_like_arbiter_checker u_chk (
    .clk        (clk),
    .resetn     (resetn),
    .in_addr    (state_r == ADDR),
    .grant_inst (grant_inst_r),
    .inst_req   (inst_req),
    .data_req   (data_req),
    .s_data_ok  (s_data_ok)
  );

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares the single SRAM-like memory port (front end of the AXI bridge) between the instruction-fetch master and the data-memory master. It runs one transaction at a time through an address phase and a data phase. Data requests have priority, and a starvation counter protects instruction fetch. It produces mem_stall, the stall_by_sram input consumed by the hazard unit, which freezes all pipeline stages while any memory access is unfinished.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants won over a waiting inst request before inst is forced first (1..15)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  inst master request, held until inst_addr_ok
inst_wr  in  1  inst write (normally 0)
inst_size  in  2  bytes-1 encoding (0=1B,1=2B,2=4B)
inst_addr  in  ADDR_W  inst address
inst_wdata  in  DATA_W  inst write data
inst_addr_ok  out  1  inst address accepted
inst_data_ok  out  1  inst transaction complete
inst_rdata  out  DATA_W  inst read data
data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/ADDR_W/DATA_W  data master, same rules as inst
data_addr_ok, data_data_ok  out  1  data handshakes
data_rdata  out  DATA_W  data read data
s_req  out  1  slave request
s_wr  out  1  slave write
s_size  out  2  slave size
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_addr_ok  in  1  slave address accepted
s_data_ok  in  1  slave data phase done
s_rdata  in  DATA_W  slave read data
mem_stall  out  1  pipeline stall request (stall_by_sram)

Behaviour:
- Reset (resetn=0, async): FSM state=IDLE, grant=DATA, starve_cnt=0, every handshake output 0, s_req=0, mem_stall=0. Any in-flight slave transaction is abandoned; the slave is reset by the same resetn.
- FSM states: IDLE, ADDR, DATA.
- IDLE, grant decision:
  - Choose inst if inst_req and (~data_req or starve_cnt==STARVE_LIMIT).
  - Otherwise choose data if data_req.
  - The chosen master is registered in grant; go to ADDR. No request: stay in IDLE.
- starve_cnt, updated at the IDLE decision:
  - Data granted while inst_req=1: increment, saturating at STARVE_LIMIT.
  - Inst granted: clear to 0.
  - Otherwise: hold.
- ADDR:
  - s_req=1. s_wr, s_size, s_addr, s_wdata are driven combinationally from the granted master's inputs.
  - Granted master's addr_ok = s_addr_ok; the other master's addr_ok=0.
  - On s_addr_ok go to DATA; otherwise stay.
- DATA:
  - s_req=0; slave address outputs are don't-care, driven 0.
  - Granted master's data_ok = s_data_ok; the other master's data_ok=0.
  - On s_data_ok go to IDLE. This costs one bubble cycle before the next grant.
- Read data: inst_rdata and data_rdata are both driven by s_rdata; only the granted master's data_ok qualifies it.
- Outside ADDR and DATA, s_* outputs are 0.
- Ordering: the slave must not return s_data_ok in the same cycle as s_addr_ok. If it does, that data_ok is ignored; this is a verification assertion.
- A master dropping req during ADDR without addr_ok is illegal (assertion). The arbiter still completes the issued transaction.
- mem_stall, combinational:
  - mem_stall = (inst_req | inst_busy) & ~inst_data_ok | (data_req | data_busy) & ~data_data_ok.
  - x_busy is 1 while grant==x and state is ADDR or DATA.
  - Consequently mem_stall deasserts in the data_ok cycle of the last outstanding access, so the pipeline advances on that edge.
- Latency with a zero-wait slave: req seen in IDLE at cycle 0, ADDR/addr_ok at cycle 1, DATA/data_ok at cycle 2. The next grant decision is at cycle 3.

Test Plan:
- Reset mid-DATA: inst transaction in DATA, resetn pulsed low asynchronously -> all outputs 0 immediately, state IDLE; next inst_req is granted normally.
- Single inst read, addr 0xBFC00000, slave returns 0x24080001 with 0 wait -> inst_addr_ok at cycle 1, inst_data_ok with rdata 0x24080001 at cycle 2, mem_stall high cycles 0-1 and low at cycle 2.
- Simultaneous inst_req and data_req, starve_cnt=0 -> data granted first; inst granted in the IDLE cycle after data_data_ok. mem_stall stays high until inst_data_ok.
- Starvation: data_req held continuously with inst_req, STARVE_LIMIT=4 -> 4 data transactions, then inst granted; starve_cnt returns to 0.
- Slave backpressure: s_addr_ok delayed 3 cycles and s_data_ok delayed 5 cycles on a data write (addr 0x80000010, size 2, wdata 0xDEADBEEF) -> s_* outputs held stable for all 3 ADDR cycles, no spurious data_ok, inst handshakes stay 0.
